// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite position generator.
// Holds the spawn FSM states, LFSR taps, default geometry and the bounce step.
package sprite_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAW_X,
    ST_DRAW_Y,
    ST_PEND
  } spawn_state_t;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] SEED_SUBST = 16'hACE1;
  localparam logic [3:0]  MAX_REJECTS = 4'd8;

  localparam int DEF_SCREEN_W = 1280;
  localparam int DEF_SCREEN_H = 720;
  localparam int DEF_SPRITE_W = 256;
  localparam int DEF_SPRITE_H = 256;

  typedef struct packed {
    logic signed [11:0] pos;
    logic signed [3:0]  vel;
  } axis_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] q);
    return {q[14:0], ^(q & LFSR_TAPS)};
  endfunction

  // One frame of motion on one axis: clamp to [0, lim] and reflect on contact.
  function automatic axis_t axis_step(input logic signed [11:0] pos,
                                      input logic signed [3:0]  vel,
                                      input logic signed [11:0] lim);
    axis_t r;
    logic signed [11:0] sum;
    sum   = pos + {{8{vel[3]}}, vel};
    r.pos = sum;
    r.vel = vel;
    if (sum < 0) begin
      r.pos = '0;
      r.vel = -vel;
    end else if (sum > lim) begin
      r.pos = lim;
      r.vel = -vel;
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_16.sv
// Free-running 16-bit Fibonacci LFSR; a zero seed is swapped for a safe constant
// so the register can never lock up in the all-zero state.
module lfsr_16
  import sprite_pkg::*;
(
  input  logic        clk_pixel,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] seed_eff;

  assign seed_eff = (seed == 16'h0000) ? SEED_SUBST : seed;

  always_ff @(posedge clk_pixel or posedge rst) begin
    if (rst) q <= seed_eff;
    else     q <= lfsr_next(q);
  end

endmodule

// File: rtl/sprite_pos_gen.sv
// Spawns sprites at random on-screen positions and optionally bounces them,
// committing every output change only on the new-frame strobe.
//
// state     | meaning
// IDLE      | waiting for a trigger rise
// DRAW_X    | drawing an x that keeps the sprite on screen
// DRAW_Y    | drawing y, pop variant and velocity
// PEND      | staged values wait for the next frame strobe
module sprite_pos_gen
  import sprite_pkg::*;
#(
  parameter int          NUM_SPRITES = 4,
  parameter int          SCREEN_W    = DEF_SCREEN_W,
  parameter int          SCREEN_H    = DEF_SCREEN_H,
  parameter int          SPRITE_W    = DEF_SPRITE_W,
  parameter int          SPRITE_H    = DEF_SPRITE_H,
  parameter logic [15:0] SEED        = 16'hDF4B
) (
  input  logic                         clk_pixel_in,
  input  logic                         rst_in,
  input  logic                         trigger_in,
  input  logic                         mode_in,
  input  logic                         nf_in,
  output logic [NUM_SPRITES-1:0][10:0] x_out,
  output logic [NUM_SPRITES-1:0][9:0]  y_out,
  output logic [NUM_SPRITES-1:0]       pop_out,
  output logic                         busy_out
);

  localparam int X_MAX = SCREEN_W - SPRITE_W;
  localparam int Y_MAX = SCREEN_H - SPRITE_H;
  localparam logic signed [11:0] X_LIM = 12'(X_MAX);
  localparam logic signed [11:0] Y_LIM = 12'(Y_MAX);
  localparam int IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_SPRITES - 1);

  logic [15:0]       lfsr_q;
  logic              trig_r, trig_d, rise;
  spawn_state_t      state;
  logic [3:0]        rej_cnt;
  logic [IDX_W-1:0]  idx;
  logic [10:0]       cand_x, x_fold, stg_x;
  logic [9:0]        cand_y, y_fold, stg_y;
  logic              x_ok, y_ok, stg_pop, commit;
  logic [3:0]        mag;
  logic signed [3:0] vx_draw, vy_draw, stg_vx, stg_vy;
  logic signed [3:0] vx [NUM_SPRITES];
  logic signed [3:0] vy [NUM_SPRITES];
  axis_t             x_nxt [NUM_SPRITES];
  axis_t             y_nxt [NUM_SPRITES];
  logic              unused_lfsr_hi, unused_pos_msb;

  lfsr_16 u_lfsr (
    .clk_pixel (clk_pixel_in),
    .rst       (rst_in),
    .seed      (SEED),
    .q         (lfsr_q)
  );

  assign unused_lfsr_hi = ^lfsr_q[15:11];

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      trig_r <= 1'b0;
      trig_d <= 1'b0;
    end else begin
      trig_r <= trigger_in;
      trig_d <= trig_r;
    end
  end

  assign rise    = trig_r & ~trig_d;
  assign cand_x  = lfsr_q[10:0];
  assign cand_y  = lfsr_q[9:0];
  assign x_ok    = $signed({1'b0, cand_x}) <= X_LIM;
  assign y_ok    = $signed({2'b00, cand_y}) <= Y_LIM;
  assign x_fold  = 11'(32'(cand_x) % (X_MAX + 1));
  assign y_fold  = 10'(32'(cand_y) % (Y_MAX + 1));
  assign mag     = {2'b00, lfsr_q[2:1]} + 4'd1;
  assign vx_draw = lfsr_q[3] ? -mag : mag;
  assign vy_draw = lfsr_q[4] ? -mag : mag;
  assign commit  = (state == ST_PEND) && nf_in;

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      state    <= ST_IDLE;
      rej_cnt  <= '0;
      idx      <= '0;
      stg_x    <= '0;
      stg_y    <= '0;
      stg_pop  <= 1'b0;
      stg_vx   <= 4'sd1;
      stg_vy   <= 4'sd1;
      busy_out <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (rise) begin
          state    <= ST_DRAW_X;
          rej_cnt  <= '0;
          busy_out <= 1'b1;
        end
        ST_DRAW_X: begin
          if (x_ok || rej_cnt == MAX_REJECTS) begin
            stg_x   <= x_ok ? cand_x : x_fold;
            rej_cnt <= '0;
            state   <= ST_DRAW_Y;
          end else begin
            rej_cnt <= rej_cnt + 4'd1;
          end
        end
        ST_DRAW_Y: begin
          if (y_ok || rej_cnt == MAX_REJECTS) begin
            stg_y   <= y_ok ? cand_y : y_fold;
            stg_pop <= lfsr_q[0];
            stg_vx  <= vx_draw;
            stg_vy  <= vy_draw;
            rej_cnt <= '0;
            state   <= ST_PEND;
          end else begin
            rej_cnt <= rej_cnt + 4'd1;
          end
        end
        ST_PEND: if (nf_in) begin
          idx      <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
          state    <= ST_IDLE;
          busy_out <= 1'b0;
        end
        default: begin
          state    <= ST_IDLE;
          busy_out <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_SPRITES; ch++) begin
      x_nxt[ch] = axis_step($signed({1'b0, x_out[ch]}), vx[ch], X_LIM);
      y_nxt[ch] = axis_step($signed({2'b00, y_out[ch]}), vy[ch], Y_LIM);
    end
  end

  // Clamped positions never exceed the screen limits, so these MSBs stay zero.
  always_comb begin
    unused_pos_msb = 1'b0;
    for (int ch = 0; ch < NUM_SPRITES; ch++)
      unused_pos_msb = unused_pos_msb ^ x_nxt[ch].pos[11] ^ (^y_nxt[ch].pos[11:10]);
  end

  always_ff @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) begin
      for (int ch = 0; ch < NUM_SPRITES; ch++) begin
        x_out[ch]   <= '0;
        y_out[ch]   <= '0;
        pop_out[ch] <= 1'b0;
        vx[ch]      <= 4'sd1;
        vy[ch]      <= 4'sd1;
      end
    end else if (nf_in) begin
      for (int ch = 0; ch < NUM_SPRITES; ch++) begin
        if (commit && idx == IDX_W'(ch)) begin
          x_out[ch]   <= stg_x;
          y_out[ch]   <= stg_y;
          pop_out[ch] <= stg_pop;
          vx[ch]      <= stg_vx;
          vy[ch]      <= stg_vy;
        end else if (mode_in) begin
          x_out[ch] <= x_nxt[ch].pos[10:0];
          y_out[ch] <= y_nxt[ch].pos[9:0];
          vx[ch]    <= x_nxt[ch].vel;
          vy[ch]    <= y_nxt[ch].vel;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_pos_gen.sv
// Directed bench for sprite_pos_gen: spawn sequencing, frame-locked commits,
// bounce clamping, trigger edge filtering and reset abandonment.
module tb_sprite_pos_gen;

  localparam int N = 4;
  localparam int XM = 1024;
  localparam int YM = 464;

  logic clk_pixel_in = 1'b0;
  logic rst_in = 1'b1;
  logic trigger_in = 1'b0;
  logic mode_in = 1'b0;
  logic nf_in = 1'b0;
  logic [N-1:0][10:0] x_out;
  logic [N-1:0][9:0]  y_out;
  logic [N-1:0]       pop_out;
  logic               busy_out;

  int n_checks = 0;
  int n_pass = 0;

  int   mx [N];
  int   my [N];
  int   mvx [N];
  int   mvy [N];
  logic mpop [N];
  int   m_idx;
  logic [15:0] m_lfsr;

  int   px, py, pvx, pvy, nxe;
  logic ppop;

  sprite_pos_gen #(
    .NUM_SPRITES (N),
    .SCREEN_W    (1280),
    .SCREEN_H    (720),
    .SPRITE_W    (256),
    .SPRITE_H    (256),
    .SEED        (16'hDF4B)
  ) dut (
    .clk_pixel_in (clk_pixel_in),
    .rst_in       (rst_in),
    .trigger_in   (trigger_in),
    .mode_in      (mode_in),
    .nf_in        (nf_in),
    .x_out        (x_out),
    .y_out        (y_out),
    .pop_out      (pop_out),
    .busy_out     (busy_out)
  );

  always #5 clk_pixel_in = ~clk_pixel_in;

  function automatic logic [15:0] tb_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // Reference LFSR, free-running from the same reset as the design.
  always @(posedge clk_pixel_in or posedge rst_in) begin
    if (rst_in) m_lfsr <= 16'hDF4B;
    else        m_lfsr <= tb_step(m_lfsr);
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      mx[c] = 0; my[c] = 0; mvx[c] = 1; mvy[c] = 1; mpop[c] = 1'b0;
    end
    m_idx = 0;
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0][10:0] ex;
    logic [N-1:0][9:0]  ey;
    logic [N-1:0]       ep;
    for (int c = 0; c < N; c++) begin
      ex[c] = 11'(mx[c]);
      ey[c] = 10'(my[c]);
      ep[c] = mpop[c];
    end
    check_val({tag, "_x"}, 64'(x_out), 64'(ex));
    check_val({tag, "_y"}, 64'(y_out), 64'(ey));
    check_val({tag, "_pop"}, 64'(pop_out), 64'(ep));
  endtask

  // Spawn outcome from the LFSR value present on the first DRAW_X cycle.
  task automatic predict(input logic [15:0] l0);
    logic [15:0] l;
    int cand, mag;
    l = l0;
    for (int i = 0; i < 9; i++) begin
      cand = int'(l[10:0]);
      if (cand <= XM || i == 8) begin
        px  = (cand <= XM) ? cand : cand % (XM + 1);
        nxe = i + 1;
        break;
      end
      l = tb_step(l);
    end
    l = tb_step(l);
    for (int i = 0; i < 9; i++) begin
      cand = int'(l[9:0]);
      if (cand <= YM || i == 8) begin
        py = (cand <= YM) ? cand : cand % (YM + 1);
        break;
      end
      l = tb_step(l);
    end
    ppop = l[0];
    mag  = int'(l[2:1]) + 1;
    pvx  = l[3] ? -mag : mag;
    pvy  = l[4] ? -mag : mag;
  endtask

  task automatic mstep(inout int p, inout int v, input int lim);
    int s;
    s = p + v;
    if (s < 0) begin
      p = 0; v = -v;
    end else if (s > lim) begin
      p = lim; v = -v;
    end else begin
      p = s;
    end
  endtask

  task automatic frame(input bit commit, input logic exp_busy, input string tag);
    @(negedge clk_pixel_in) nf_in = 1'b1;
    @(negedge clk_pixel_in) nf_in = 1'b0;
    for (int c = 0; c < N; c++) begin
      if (commit && c == m_idx) begin
        mx[c] = px; my[c] = py; mvx[c] = pvx; mvy[c] = pvy; mpop[c] = ppop;
      end else if (mode_in) begin
        mstep(mx[c], mvx[c], XM);
        mstep(my[c], mvy[c], YM);
      end
    end
    if (commit) m_idx = (m_idx + 1) % N;
    check_all(tag);
    check_val({tag, "_busy"}, 64'(busy_out), 64'(exp_busy));
  endtask

  task automatic do_spawn(input bit keep_high, input bit glitch, input string tag);
    @(negedge clk_pixel_in) trigger_in = 1'b1;
    @(negedge clk_pixel_in);
    check_val({tag, "_busy_pre"}, 64'(busy_out), 64'd0);
    @(negedge clk_pixel_in);
    check_val({tag, "_busy_on"}, 64'(busy_out), 64'd1);
    predict(m_lfsr);
    if (!keep_high) trigger_in = 1'b0;
    if (glitch) begin
      trigger_in = 1'b0;
      repeat (2) @(negedge clk_pixel_in);
      trigger_in = 1'b1;
    end
    repeat (20) @(negedge clk_pixel_in);
    check_val({tag, "_busy_pend"}, 64'(busy_out), 64'd1);
    check_all({tag, "_pre_nf"});
    frame(1'b1, 1'b0, tag);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk_pixel_in);
    rst_in = 1'b0;
    check_all("reset");
    check_val("reset_busy", 64'(busy_out), 64'd0);
    repeat (3) frame(1'b0, 1'b0, "idle_frame");

    do_spawn(1'b0, 1'b0, "spawn_ch0");
    check_val("ch0_x_bound", 64'(x_out[0] <= 11'd1024), 64'd1);
    check_val("ch0_y_bound", 64'(y_out[0] <= 10'd464), 64'd1);
    do_spawn(1'b0, 1'b0, "spawn_ch1");
    do_spawn(1'b0, 1'b0, "spawn_ch2");
    do_spawn(1'b0, 1'b0, "spawn_ch3");
    do_spawn(1'b0, 1'b0, "spawn_ch0_again");

    do_spawn(1'b1, 1'b0, "hold");
    repeat (100) @(negedge clk_pixel_in);
    check_val("hold_no_respawn", 64'(busy_out), 64'd0);
    trigger_in = 1'b0;
    frame(1'b0, 1'b0, "hold_after");

    do_spawn(1'b0, 1'b1, "busy_rise");
    repeat (10) @(negedge clk_pixel_in);
    check_val("busy_rise_dropped", 64'(busy_out), 64'd0);
    trigger_in = 1'b0;

    mode_in = 1'b1;
    repeat (1100) frame(1'b0, 1'b0, "bounce");
    do_spawn(1'b0, 1'b0, "bounce_spawn");
    repeat (50) frame(1'b0, 1'b0, "bounce_post");

    mode_in = 1'b0;
    repeat (5) frame(1'b0, 1'b0, "teleport_hold");
    mode_in = 1'b1;
    repeat (20) frame(1'b0, 1'b0, "bounce_resume");

    mode_in = 1'b0;
    @(negedge clk_pixel_in) trigger_in = 1'b1;
    @(negedge clk_pixel_in);
    @(negedge clk_pixel_in);
    predict(m_lfsr);
    trigger_in = 1'b0;
    repeat (nxe) @(negedge clk_pixel_in);
    check_val("draw_y_busy", 64'(busy_out), 64'd1);
    rst_in = 1'b1;
    @(negedge clk_pixel_in) rst_in = 1'b0;
    model_reset();
    check_all("mid_reset");
    check_val("mid_reset_busy", 64'(busy_out), 64'd0);
    repeat (2) frame(1'b0, 1'b0, "mid_reset_frame");
    do_spawn(1'b0, 1'b0, "post_reset_ch0");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
